// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per ADD/SHIFT cycle pair,
// with a ready/start handshake and a one-cycle done pulse that accompanies each new product.
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     multiplicand_i,
   input  logic [WIDTH-1:0]     multiplier_i,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   product_o,
   output logic                 done_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [WIDTH-1:0]     r_m;
   logic [WIDTH-1:0]     r_q;
   logic [WIDTH:0]       r_acc;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_accept;
   logic [WIDTH:0]       w_acc_shift;
   logic [WIDTH-1:0]     w_q_shift;
   logic [CW-1:0]        w_cnt_inc;
   logic                 w_last;

   assign ready_o   = (r_state == S_IDLE) || (r_state == S_DONE);
   assign done_o    = (r_state == S_DONE);
   assign product_o = r_product;
   assign w_accept  = start_i && ready_o;

   // {carry, acc_hi, Q} shifted right by one as a single 2*WIDTH+1 bit word
   assign w_acc_shift = {1'b0, r_acc[WIDTH:1]};
   assign w_q_shift   = {r_acc[0], r_q[WIDTH-1:1]};
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_last      = (w_cnt_inc == CW'(WIDTH));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_ADD;
         S_ADD:   w_state_next = S_SHIFT;
         S_SHIFT: w_state_next = w_last ? S_DONE : S_ADD;
         S_DONE:  w_state_next = w_accept ? S_ADD : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_q       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_m   <= multiplicand_i;
            r_q   <= multiplier_i;
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            case (r_state)
               S_ADD: begin
                  if (r_q[0]) r_acc <= r_acc + {1'b0, r_m};
               end
               S_SHIFT: begin
                  r_acc <= w_acc_shift;
                  r_q   <= w_q_shift;
                  r_cnt <= w_cnt_inc;
                  // Publish the post-shift value on the same edge that enters DONE
                  if (w_last) r_product <= {w_acc_shift[WIDTH-1:0], w_q_shift};
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier (WIDTH=8): latency, handshake,
// ignored starts, mid-operation reset and back-to-back operation.
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [7:0]  multiplicand_i;
   logic [7:0]  multiplier_i;
   logic        ready_o;
   logic [15:0] product_o;
   logic        done_o;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_prod = '0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          mode;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .multiplicand_i (multiplicand_i),
      .multiplier_i   (multiplier_i),
      .ready_o        (ready_o),
      .product_o      (product_o),
      .done_o         (done_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Starts at a negedge where ready_o is expected high; returns at the negedge of the DONE cycle.
   // mode 1 pulses start_i once in an ADD cycle and once in a SHIFT cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input int mode);
      chk("ready_before_start", ready_o, 1);
      start_i        = 1'b1;
      multiplicand_i = a;
      multiplier_i   = b;
      @(negedge clk);
      start_i        = 1'b0;
      multiplicand_i = 8'hFF;
      multiplier_i   = 8'hFF;
      for (int k = 0; k < 16; k++) begin
         chk("busy_ready", ready_o, 0);
         chk("busy_done", done_o, 0);
         chk("busy_product_hold", product_o, exp_prod);
         if (mode == 1) start_i = (k == 2 || k == 5);
         @(negedge clk);
      end
      start_i  = 1'b0;
      exp_prod = p;
      chk("done_pulse", done_o, 1);
      chk("product", product_o, p);
      chk("done_ready", ready_o, 1);
      $display("op %0d x %0d -> product=%0d expected=%0d", a, b, product_o, p);
   endtask

   task automatic idle_check(input int n);
      start_i = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_done_low", done_o, 0);
         chk("idle_ready", ready_o, 1);
         chk("idle_product_hold", product_o, exp_prod);
      end
   endtask

   task automatic reset_mid(input logic [7:0] a, input logic [7:0] b, input int k);
      start_i        = 1'b1;
      multiplicand_i = a;
      multiplier_i   = b;
      @(negedge clk);
      start_i = 1'b0;
      repeat (k) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_prod = '0;
      chk("rst_mid_ready", ready_o, 1);
      chk("rst_mid_product", product_o, 0);
      chk("rst_mid_done", done_o, 0);
      $display("reset during %0d x %0d at cycle %0d -> ready=%0d product=%0d", a, b, k, ready_o, product_o);
      idle_check(20);
   endtask

   initial begin
      logic [7:0] vals[10];
      logic [7:0] va;
      logic [7:0] vb;
      logic [15:0] vp;

      tbl[0]  = '{8'd13,  8'd11,  16'd143,   0};
      tbl[1]  = '{8'd0,   8'd0,   16'd0,     0};
      tbl[2]  = '{8'd255, 8'd0,   16'd0,     0};
      tbl[3]  = '{8'd255, 8'd255, 16'd65025, 0};
      tbl[4]  = '{8'd7,   8'd9,   16'd63,    1};
      tbl[5]  = '{8'd1,   8'd1,   16'd1,     0};
      tbl[6]  = '{8'd128, 8'd2,   16'd256,   0};
      tbl[7]  = '{8'd255, 8'd1,   16'd255,   0};
      tbl[8]  = '{8'd1,   8'd255, 16'd255,   0};
      tbl[9]  = '{8'd170, 8'd85,  16'd14450, 0};
      tbl[10] = '{8'd16,  8'd16,  16'd256,   0};
      tbl[11] = '{8'd3,   8'd200, 16'd600,   1};

      vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd15, 8'd127, 8'd128, 8'd170, 8'd254, 8'd255};

      rst            = 1'b1;
      start_i        = 1'b0;
      multiplicand_i = '0;
      multiplier_i   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", ready_o, 1);
      chk("reset_done", done_o, 0);
      chk("reset_product", product_o, 0);

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].mode);
         idle_check(3);
      end

      reset_mid(8'd200, 8'd3, 4);
      run_op(8'd5, 8'd5, 16'd25, 0);
      idle_check(2);
      reset_mid(8'd200, 8'd3, 7);
      run_op(8'd5, 8'd5, 16'd25, 0);

      // Reset while in DONE
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_prod = '0;
      chk("rst_done_product", product_o, 0);
      chk("rst_done_done", done_o, 0);
      chk("rst_done_ready", ready_o, 1);
      $display("reset in DONE -> product=%0d", product_o);

      // Reset and start together: reset wins, block stays idle
      rst            = 1'b1;
      start_i        = 1'b1;
      multiplicand_i = 8'd9;
      multiplier_i   = 8'd9;
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;
      chk("rst_start_ready", ready_o, 1);
      $display("reset with start -> ready=%0d done=%0d", ready_o, done_o);
      idle_check(20);

      // Back-to-back: 6x7 started in the DONE cycle of 12x12
      run_op(8'd12, 8'd12, 16'd144, 0);
      run_op(8'd6, 8'd7, 16'd42, 0);
      idle_check(2);

      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 10; j++) begin
            va = vals[i];
            vb = vals[(j + i) % 10];
            vp = 16'(va) * 16'(vb);
            run_op(va, vb, vp, (i + j) % 3 == 0 ? 1 : 0);
         end
      end
      idle_check(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
